// File: rtl/ti_pkg.sv
// Shared definitions for the task-stop controller: FSM encodings, stop_req
// bit mapping and the ack-reduction polarity selector.
package ti_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_FREEZE  = 3'd2,
    ST_HALTED  = 3'd3,
    ST_THAW    = 3'd4,
    ST_RELEASE = 3'd5
  } ti_state_e;

  // Within each port's 2-bit stop_req/stop_ack slice.
  localparam int unsigned WR_BIT = 0;
  localparam int unsigned RD_BIT = 1;

  typedef enum logic {
    RED_ALL_SET   = 1'b0,
    RED_ALL_CLEAR = 1'b1
  } ti_reduce_e;

endpackage

// File: rtl/ti_ack_reduce.sv
// Masks the per-port stop_ack pairs with the enabled-port set and reduces them
// to "every enabled ack is set" or "every enabled ack is clear".
module ti_ack_reduce
  import ti_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter ti_reduce_e  POLARITY  = RED_ALL_SET
) (
  input  logic [2*NUM_PORTS-1:0] ack,
  input  logic [NUM_PORTS-1:0]   en,
  output logic                   result
);

  logic [2*NUM_PORTS-1:0] mask;

  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      mask[2*i+WR_BIT] = en[i];
      mask[2*i+RD_BIT] = en[i];
    end
  end

  // An empty mask yields 1 for both polarities.
  if (POLARITY == RED_ALL_SET) begin : g_and
    assign result = &(ack | ~mask);
  end else begin : g_nor
    assign result = ~|(ack & mask);
  end

endmodule

// File: rtl/ti_stop_controller.sv
// Halt sequencer for a task wrapped by per-port AXI stop wrappers: drains the
// enabled ports, gates the user clock, then thaws and releases on request.
module ti_stop_controller
  import ti_pkg::*;
#(
  parameter int unsigned NUM_PORTS    = 4,
  parameter int unsigned TIMEOUT_BITS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    halt_req,
  input  logic [NUM_PORTS-1:0]    port_en,
  input  logic [TIMEOUT_BITS-1:0] timeout_limit,
  output logic [2*NUM_PORTS-1:0]  stop_req,
  input  logic [2*NUM_PORTS-1:0]  stop_ack,
  output logic                    clk_en,
  output logic                    halted,
  output logic                    timeout_err,
  output logic [2:0]              state
);

  ti_state_e              state_q, state_n;
  logic [NUM_PORTS-1:0]   en_q, en_n;
  logic [TIMEOUT_BITS-1:0] cnt_q, cnt_inc;
  logic [2*NUM_PORTS-1:0] stop_q, stop_n;
  logic                   clk_en_q, halted_q, terr_q;
  logic                   all_ack, all_clear;
  logic                   start, timeout_hit, hold;

  ti_ack_reduce #(.NUM_PORTS(NUM_PORTS), .POLARITY(RED_ALL_SET)) u_red_set (
    .ack    (stop_ack),
    .en     (en_q),
    .result (all_ack)
  );

  ti_ack_reduce #(.NUM_PORTS(NUM_PORTS), .POLARITY(RED_ALL_CLEAR)) u_red_clear (
    .ack    (stop_ack),
    .en     (en_q),
    .result (all_clear)
  );

  // cnt_inc counts DRAIN cycles including the current one, so a limit of N
  // allows exactly N DRAIN cycles before aborting.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign start   = (state_q == ST_IDLE) && halt_req;
  assign en_n    = start ? port_en : en_q;

  always_comb begin
    state_n     = state_q;
    timeout_hit = 1'b0;
    case (state_q)
      ST_IDLE:    if (halt_req) state_n = ST_DRAIN;
      ST_DRAIN: begin
        if (all_ack) begin
          state_n = ST_FREEZE;
        end else if ((timeout_limit != '0) && (cnt_inc == timeout_limit)) begin
          state_n     = ST_RELEASE;
          timeout_hit = 1'b1;
        end
      end
      ST_FREEZE:  state_n = ST_HALTED;
      ST_HALTED:  if (!halt_req) state_n = ST_THAW;
      ST_THAW:    state_n = ST_RELEASE;
      ST_RELEASE: if (all_clear) state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they track state_q exactly.
  always_comb begin
    hold   = (state_n == ST_DRAIN) || (state_n == ST_FREEZE) ||
             (state_n == ST_HALTED) || (state_n == ST_THAW);
    stop_n = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      stop_n[2*i+WR_BIT] = hold & en_n[i];
      stop_n[2*i+RD_BIT] = hold & en_n[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      en_q     <= '0;
      cnt_q    <= '0;
      stop_q   <= '0;
      clk_en_q <= 1'b1;
      halted_q <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      en_q     <= en_n;
      if (start)                    cnt_q <= '0;
      else if (state_q == ST_DRAIN) cnt_q <= cnt_inc;
      stop_q   <= stop_n;
      clk_en_q <= !((state_n == ST_FREEZE) || (state_n == ST_HALTED));
      halted_q <= (state_n == ST_HALTED);
      if (start)            terr_q <= 1'b0;
      else if (timeout_hit) terr_q <= 1'b1;
    end
  end

  assign stop_req    = stop_q;
  assign clk_en      = clk_en_q;
  assign halted      = halted_q;
  assign timeout_err = terr_q;
  assign state       = state_q;

endmodule

// File: tb/tb_ti_stop_controller.sv
// Directed bench for ti_stop_controller: the driver pushes the hand-computed
// output snapshot for each cycle; a negedge monitor pops and compares.
module tb_ti_stop_controller;
  import ti_pkg::*;

  localparam int W = 14;  // {state[3], stop_req[8], clk_en, halted, timeout_err}

  logic        clk = 1'b0;
  logic        rst;
  logic        halt_req;
  logic [3:0]  port_en;
  logic [15:0] timeout_limit;
  logic [7:0]  stop_req;
  logic [7:0]  stop_ack;
  logic        clk_en;
  logic        halted;
  logic        timeout_err;
  logic [2:0]  state;

  logic [W-1:0] exp_q[$];
  int           id_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  int           step_id  = 0;

  ti_stop_controller #(.NUM_PORTS(4), .TIMEOUT_BITS(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .halt_req      (halt_req),
    .port_en       (port_en),
    .timeout_limit (timeout_limit),
    .stop_req      (stop_req),
    .stop_ack      (stop_ack),
    .clk_en        (clk_en),
    .halted        (halted),
    .timeout_err   (timeout_err),
    .state         (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [W-1:0] obs(input ti_state_e st, input logic [7:0] sr,
                                       input logic ce, input logic h, input logic te);
    return {st, sr, ce, h, te};
  endfunction

  // one clock edge, then record what the outputs must be for the new cycle
  task automatic cyc(input ti_state_e st, input logic [7:0] sr,
                     input logic ce, input logic h, input logic te);
    @(posedge clk);
    #1;
    step_id++;
    exp_q.push_back(obs(st, sr, ce, h, te));
    id_q.push_back(step_id);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      int           id;
      e  = exp_q.pop_front();
      id = id_q.pop_front();
      a  = {state, stop_req, clk_en, halted, timeout_err};
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL step%0d got st=%0d sr=%h ce=%b h=%b te=%b exp st=%0d sr=%h ce=%b h=%b te=%b",
                    id, a[13:11], a[10:3], a[2], a[1], a[0],
                    e[13:11], e[10:3], e[2], e[1], e[0]);
    end
  end

  initial begin
    rst = 1'b1; halt_req = 1'b0; port_en = 4'hF; timeout_limit = '0; stop_ack = '0;
    cyc(ST_IDLE, 8'h00, 1, 0, 0);
    cyc(ST_IDLE, 8'h00, 1, 0, 0);
    rst = 1'b0;

    // full drain with acks after 10 DRAIN cycles, hold, thaw, release
    halt_req = 1'b1;
    for (int i = 0; i < 10; i++) cyc(ST_DRAIN, 8'hFF, 1, 0, 0);
    stop_ack = 8'hFF;
    cyc(ST_FREEZE, 8'hFF, 0, 0, 0);
    cyc(ST_HALTED, 8'hFF, 0, 1, 0);
    cyc(ST_HALTED, 8'hFF, 0, 1, 0);
    halt_req = 1'b0;
    cyc(ST_THAW, 8'hFF, 1, 0, 0);
    cyc(ST_RELEASE, 8'h00, 1, 0, 0);
    cyc(ST_RELEASE, 8'h00, 1, 0, 0);
    stop_ack = 8'h00;
    cyc(ST_IDLE, 8'h00, 1, 0, 0);

    // partial mask: ports 0 and 2, acks from 1 and 3 ignored
    port_en = 4'b0101; stop_ack = 8'hCC; halt_req = 1'b1;
    cyc(ST_DRAIN, 8'h33, 1, 0, 0);
    cyc(ST_DRAIN, 8'h33, 1, 0, 0);
    stop_ack = 8'h03;
    cyc(ST_DRAIN, 8'h33, 1, 0, 0);
    stop_ack = 8'h33;
    cyc(ST_FREEZE, 8'h33, 0, 0, 0);
    halt_req = 1'b0;
    cyc(ST_HALTED, 8'h33, 0, 1, 0);
    cyc(ST_THAW, 8'h33, 1, 0, 0);
    cyc(ST_RELEASE, 8'h00, 1, 0, 0);
    stop_ack = 8'hCC;
    cyc(ST_IDLE, 8'h00, 1, 0, 0);

    // timeout after exactly 8 DRAIN cycles, then re-drain clears the flag
    port_en = 4'hF; stop_ack = 8'h00; timeout_limit = 16'd8; halt_req = 1'b1;
    for (int i = 0; i < 8; i++) cyc(ST_DRAIN, 8'hFF, 1, 0, 0);
    cyc(ST_RELEASE, 8'h00, 1, 0, 1);
    cyc(ST_IDLE, 8'h00, 1, 0, 1);
    cyc(ST_DRAIN, 8'hFF, 1, 0, 0);
    halt_req = 1'b0; stop_ack = 8'hFF;
    cyc(ST_FREEZE, 8'hFF, 0, 0, 0);
    cyc(ST_HALTED, 8'hFF, 0, 1, 0);
    stop_ack = 8'h00;
    cyc(ST_THAW, 8'hFF, 1, 0, 0);
    cyc(ST_RELEASE, 8'h00, 1, 0, 0);
    cyc(ST_IDLE, 8'h00, 1, 0, 0);

    // one-cycle halt pulse with instant acks: one HALTED cycle
    timeout_limit = '0; stop_ack = 8'hFF; halt_req = 1'b1;
    cyc(ST_DRAIN, 8'hFF, 1, 0, 0);
    halt_req = 1'b0;
    cyc(ST_FREEZE, 8'hFF, 0, 0, 0);
    cyc(ST_HALTED, 8'hFF, 0, 1, 0);
    cyc(ST_THAW, 8'hFF, 1, 0, 0);
    stop_ack = 8'h00;
    cyc(ST_RELEASE, 8'h00, 1, 0, 0);
    cyc(ST_IDLE, 8'h00, 1, 0, 0);
    cyc(ST_IDLE, 8'h00, 1, 0, 0);

    // no ports enabled: DRAIN exits on its first cycle
    port_en = 4'h0; halt_req = 1'b1;
    cyc(ST_DRAIN, 8'h00, 1, 0, 0);
    halt_req = 1'b0;
    cyc(ST_FREEZE, 8'h00, 0, 0, 0);
    cyc(ST_HALTED, 8'h00, 0, 1, 0);
    cyc(ST_THAW, 8'h00, 1, 0, 0);
    cyc(ST_RELEASE, 8'h00, 1, 0, 0);
    cyc(ST_IDLE, 8'h00, 1, 0, 0);

    // reset while HALTED
    port_en = 4'hF; stop_ack = 8'hFF; halt_req = 1'b1;
    cyc(ST_DRAIN, 8'hFF, 1, 0, 0);
    cyc(ST_FREEZE, 8'hFF, 0, 0, 0);
    cyc(ST_HALTED, 8'hFF, 0, 1, 0);
    rst = 1'b1;
    cyc(ST_IDLE, 8'h00, 1, 0, 0);
    rst = 1'b0; halt_req = 1'b0; stop_ack = 8'h00;
    cyc(ST_IDLE, 8'h00, 1, 0, 0);

    // limit of 1: abort on first DRAIN cycle; reset clears the sticky flag
    timeout_limit = 16'd1; halt_req = 1'b1;
    cyc(ST_DRAIN, 8'hFF, 1, 0, 0);
    halt_req = 1'b0;
    cyc(ST_RELEASE, 8'h00, 1, 0, 1);
    cyc(ST_IDLE, 8'h00, 1, 0, 1);
    rst = 1'b1;
    cyc(ST_IDLE, 8'h00, 1, 0, 0);
    rst = 1'b0;

    // let the monitor drain the queue, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_queue got %0d left exp 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
